// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_types_pkg                                          |
// | Description : Shared CPU pipeline types: machine word, skid-stage    |
// |               occupancy states and the NOP encoding used as bubble.  |
// | Revision    : 1.0 - elastic IF/ID stage types                        |
// +----------------------------------------------------------------------+
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Occupancy of the IF/ID skid stage, encoded directly from the valid
    // bits as {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } skid_state_t;

    // All-zero word decodes as sll $0,$0,0, a harmless NOP.
    localparam word_t NOP_INSTR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/ifid_skid_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifid_skid_if                                           |
// | Description : Handshake bundle between fetch, the IF/ID skid stage   |
// |               and decode.                                            |
// | Revision    : 1.0 - initial valid/ready bundle                       |
// +----------------------------------------------------------------------+
interface ifid_skid_if #(
    parameter int IW = 32,
    parameter int AW = 32
) (
    input logic CLK
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic [AW-1:0] in_npc;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_npc;
    logic [1:0]    occupancy;

    modport stage (
        input  CLK, in_valid, in_instr, in_npc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_npc, occupancy
    );

    modport tb (
        input  CLK, in_ready, out_valid, out_instr, out_npc, occupancy,
        output in_valid, in_instr, in_npc, flush, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/ifid_skid_stage_pipe_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_slot                                              |
// | Description : One pipeline holding slot: a valid bit plus a data     |
// |               register with load enable and clear.                   |
// | Revision    : 1.0 - initial                                          |
// +----------------------------------------------------------------------+
module pipe_slot #(
    parameter int W = 64
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Valid bit: clear wins over load so a flush always empties the slot.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // Payload is never reset; it is only observed while r_valid is set.
    always_ff @(posedge CLK) begin
        if (i_load && !i_clear) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/ifid_skid_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifid_skid_stage                                        |
// | Description : Elastic IF/ID pipeline register. A main slot drives    |
// |               decode, a skid slot absorbs the word in flight when    |
// |               decode stalls, so in_ready can be a pure flop output.  |
// | Revision    : 1.0 - replaces the fixed enable-based IF/ID latch      |
// +----------------------------------------------------------------------+
module ifid_skid_stage
    import cpu_types_pkg::*;
#(
    parameter int            IW     = 32,
    parameter int            AW     = 32,
    parameter logic [IW-1:0] BUBBLE = IW'(NOP_INSTR)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_npc,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_npc,
    output logic [1:0]    occupancy
);

    localparam int c_DW = IW + AW;

    logic            w_main_valid;
    logic            w_skid_valid;
    logic [c_DW-1:0] w_main_q;
    logic [c_DW-1:0] w_skid_q;
    logic [c_DW-1:0] w_main_d;
    logic [c_DW-1:0] w_in_word;

    logic            w_accept;
    logic            w_consume;
    logic            w_main_load;
    logic            w_main_clear;
    logic            w_main_from_skid;
    logic            w_skid_load;
    logic            w_skid_clear;
    skid_state_t     w_state;

    assign w_in_word = {in_instr, in_npc};
    assign w_accept  = in_valid & in_ready;
    assign w_consume = w_main_valid & out_ready;

    // Decode the current state from the two slot valid bits.
    always_comb begin
        w_state = EMPTY;
        case ({w_skid_valid, w_main_valid})
            2'b01:   w_state = HALF;
            2'b11:   w_state = FULL;
            default: w_state = EMPTY;
        endcase
    end

    // Next-state control: decides which slot loads, clears or shifts.
    always_comb begin
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;

        if (flush) begin
            // Squash everything; a same-cycle accept is dropped.
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (w_state)
                EMPTY: begin
                    // Skid cannot be live without main; clearing it here
                    // also recovers from the unreachable {1,0} encoding.
                    w_skid_clear = 1'b1;
                    if (w_accept) begin
                        w_main_load = 1'b1;
                    end
                end
                HALF: begin
                    if (w_accept && w_consume) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                    end else if (w_consume) begin
                        w_main_clear = 1'b1;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the shift can occur.
                    if (w_consume) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_word;

    pipe_slot #(
        .W (c_DW)
    ) u_main_slot (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_valid),
        .o_data  (w_main_q)
    );

    pipe_slot #(
        .W (c_DW)
    ) u_skid_slot (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_word),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_q)
    );

    // in_ready is a flop output: the stage can take a word whenever the
    // skid slot is free, which keeps decode stalls off the fetch path.
    assign in_ready  = ~w_skid_valid;
    assign out_valid = w_main_valid;
    assign out_instr = w_main_valid ? w_main_q[c_DW-1:AW] : BUBBLE;
    assign out_npc   = w_main_valid ? w_main_q[AW-1:0]    : '0;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule
`default_nettype wire

// File: tb/tb_ifid_skid_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ifid_skid_stage                                     |
// | Description : Scoreboard bench for ifid_skid_stage (32/32 default    |
// |               instance plus a narrow 16/12 instance).                |
// | Revision    : 1.0 - initial                                          |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ifid_skid_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    logic r_clk = 1'b0;
    logic r_rst_n;
    always #5 r_clk = ~r_clk;

    ifid_skid_if #(.IW(32), .AW(32)) bus (.CLK(r_clk));

    ifid_skid_stage u_dut (
        .CLK       (r_clk),
        .nRST      (r_rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_instr  (bus.in_instr),
        .in_npc    (bus.in_npc),
        .flush     (bus.flush),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_instr (bus.out_instr),
        .out_npc   (bus.out_npc),
        .occupancy (bus.occupancy)
    );

    logic        r_s_in_valid, r_s_flush, r_s_out_ready;
    logic [15:0] r_s_in_instr;
    logic [11:0] r_s_in_npc;
    logic        w_s_in_ready, w_s_out_valid;
    logic [15:0] w_s_out_instr;
    logic [11:0] w_s_out_npc;
    logic [1:0]  w_s_occupancy;

    ifid_skid_stage #(
        .IW     (16),
        .AW     (12),
        .BUBBLE (16'hFFFF)
    ) u_dut_small (
        .CLK       (r_clk),
        .nRST      (r_rst_n),
        .in_valid  (r_s_in_valid),
        .in_ready  (w_s_in_ready),
        .in_instr  (r_s_in_instr),
        .in_npc    (r_s_in_npc),
        .flush     (r_s_flush),
        .out_valid (w_s_out_valid),
        .out_ready (r_s_out_ready),
        .out_instr (w_s_out_instr),
        .out_npc   (w_s_out_npc),
        .occupancy (w_s_occupancy)
    );

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare the visible state of the wide instance with the model queue.
    task automatic check_model();
        int sz;
        sz = q_exp.size();
        chk("out_valid", 64'(bus.out_valid), 64'(sz != 0));
        chk("occupancy", 64'(bus.occupancy), 64'(sz));
        chk("in_ready", 64'(bus.in_ready), 64'(sz < 2));
        if (sz == 0) begin
            chk("bubble_instr", 64'(bus.out_instr), 64'h0);
            chk("bubble_npc", 64'(bus.out_npc), 64'h0);
        end else begin
            chk("out_instr", 64'(bus.out_instr), 64'(q_exp[0].instr));
            chk("out_npc", 64'(bus.out_npc), 64'(q_exp[0].npc));
        end
    endtask

    // One cycle on the wide instance; entered and left just after a negedge.
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] npc,
                        input logic ordy, input logic fl);
        int   sz;
        logic acc;
        exp_t e;
        bus.in_valid  = v;
        bus.in_instr  = v ? instr : 32'hxxxx_xxxx;
        bus.in_npc    = v ? npc   : 32'hxxxx_xxxx;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        check_model();
        sz  = q_exp.size();
        acc = v && (sz < 2);
        if (sz > 0 && ordy) begin
            void'(q_exp.pop_front());
        end
        if (fl) begin
            q_exp.delete();
        end else if (acc) begin
            e.instr = instr;
            e.npc   = npc;
            q_exp.push_back(e);
        end
        @(posedge r_clk);
        @(negedge r_clk);
    endtask

    task automatic s_cycle();
        @(posedge r_clk);
        @(negedge r_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        r_rst_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_npc    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        r_s_in_valid  = 1'b0;
        r_s_in_instr  = '0;
        r_s_in_npc    = '0;
        r_s_flush     = 1'b0;
        r_s_out_ready = 1'b0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge r_clk);
            bus.in_valid  = 1'($urandom);
            bus.in_instr  = $urandom;
            bus.in_npc    = $urandom;
            bus.flush     = 1'($urandom);
            bus.out_ready = 1'($urandom);
            #1;
            chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
            chk("rst_out_instr", 64'(bus.out_instr), 64'h0);
            chk("rst_out_npc", 64'(bus.out_npc), 64'h0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
            chk("rst_occupancy", 64'(bus.occupancy), 64'h0);
        end
        @(negedge r_clk);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        r_rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming at full rate.
        step(1'b1, 32'h8C01_0004, 32'd4,  1'b1, 1'b0);
        step(1'b1, 32'h0022_1820, 32'd8,  1'b1, 1'b0);
        step(1'b1, 32'hAC03_0008, 32'd12, 1'b1, 1'b0);
        step(1'b1, 32'h1000_0002, 32'd16, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure: fill, attempt a blocked push, then drain.
        step(1'b1, 32'h1111_1111, 32'd4, 1'b0, 1'b0);
        step(1'b1, 32'h2222_2222, 32'd8, 1'b0, 1'b0);
        step(1'b1, 32'h5555_5555, 32'd9, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while FULL with a word offered.
        step(1'b1, 32'hA1A1_A1A1, 32'd20, 1'b0, 1'b0);
        step(1'b1, 32'hA2A2_A2A2, 32'd24, 1'b0, 1'b0);
        step(1'b1, 32'h3333_3333, 32'd28, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        // Flush in HALF with an accept and a consume in the same cycle.
        step(1'b1, 32'hB1B1_B1B1, 32'd32, 1'b0, 1'b0);
        step(1'b1, 32'h3333_3333, 32'd36, 1'b1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges while FULL.
        step(1'b1, 32'hC1C1_C1C1, 32'd40, 1'b0, 1'b0);
        step(1'b1, 32'hC2C2_C2C2, 32'd44, 1'b0, 1'b0);
        #2;
        r_rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("arst_out_instr", 64'(bus.out_instr), 64'h0);
        chk("arst_out_npc", 64'(bus.out_npc), 64'h0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'h1);
        chk("arst_occupancy", 64'(bus.occupancy), 64'h0);
        q_exp.delete();
        @(negedge r_clk);
        r_rst_n = 1'b1;
        step(1'b1, 32'h4444_4444, 32'd4, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end

        // Narrow instance: bubble value and the backpressure scenario.
        #1;
        chk("s_idle_instr", 64'(w_s_out_instr), 64'hFFFF);
        chk("s_idle_npc", 64'(w_s_out_npc), 64'h0);
        chk("s_idle_valid", 64'(w_s_out_valid), 64'h0);
        r_s_in_valid  = 1'b1;
        r_s_in_instr  = 16'h1111;
        r_s_in_npc    = 12'h004;
        r_s_out_ready = 1'b0;
        s_cycle();
        chk("s_occ1", 64'(w_s_occupancy), 64'h1);
        chk("s_first_instr", 64'(w_s_out_instr), 64'h1111);
        chk("s_first_npc", 64'(w_s_out_npc), 64'h004);
        r_s_in_instr = 16'h2222;
        r_s_in_npc   = 12'h008;
        s_cycle();
        chk("s_occ2", 64'(w_s_occupancy), 64'h2);
        chk("s_full_in_ready", 64'(w_s_in_ready), 64'h0);
        chk("s_hold_instr", 64'(w_s_out_instr), 64'h1111);
        r_s_in_valid  = 1'b0;
        r_s_out_ready = 1'b1;
        s_cycle();
        chk("s_second_instr", 64'(w_s_out_instr), 64'h2222);
        chk("s_second_npc", 64'(w_s_out_npc), 64'h008);
        chk("s_half_in_ready", 64'(w_s_in_ready), 64'h1);
        s_cycle();
        chk("s_drain_valid", 64'(w_s_out_valid), 64'h0);
        chk("s_drain_instr", 64'(w_s_out_instr), 64'hFFFF);
        chk("s_drain_occ", 64'(w_s_occupancy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
